clock_domain_sender: RTL and testbench

//  Source-side companion to the toggle-based clock domain adapter.
//  - Accepts samples from a valid/ready stream on CLK.
//  - Issues single-cycle CHANGE_FLAG_OUT pulses and holds DATA_OUT stable so the

---
 rtl/clock_domain_pkg.sv | 20 ++
 rtl/bit_synchronizer.sv | 25 ++
 rtl/clock_domain_sender.sv | 183 ++++++++++++++++++
 tb/tb_clock_domain_sender.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_domain_pkg.sv
// Shared types and sizing helpers for the toggle-based clock domain adapter.
package clock_domain_pkg;

  // Source-side sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } sender_state_t;

  // Bits needed for a down-counter that is loaded with (num_cycles - 1).
  function automatic int unsigned cnt_width(input int unsigned num_cycles);
    return (num_cycles < 2) ? 1 : $clog2(num_cycles);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single slow-changing level (e.g. a toggle).
module bit_synchronizer (
  input  logic CLK,
  input  logic RESET,
  input  logic SYNC_IN,
  output logic SYNC_OUT
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives the resolved level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= SYNC_IN;
      sync_q <= meta_q;
    end
  end

  assign SYNC_OUT = sync_q;

endmodule

// File: rtl/clock_domain_sender.sv
// Source side of the toggle-based clock domain adapter. Turns a valid/ready
// stream into rate-limited CHANGE_FLAG_OUT pulses with DATA_OUT held stable,
// optionally waiting for an acknowledge toggle from the destination domain.
module clock_domain_sender
  import clock_domain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter bit          USE_ACK        = 1'b0,
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter bit          OVERWRITE      = 1'b1,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_WIDTH-1:0]     IN_DATA,
  output logic                      CHANGE_FLAG_OUT,
  output logic [DATA_WIDTH-1:0]     DATA_OUT,
  input  logic                      ACK_TOGGLE_IN,
  output logic                      BUSY,
  output logic                      TIMEOUT,
  output logic [DROP_CNT_WIDTH-1:0] DROP_COUNT
);

  // One shared down-counter serves both the hold window and the ack timeout.
  localparam int unsigned TIMER_W = cnt_width(max_u(HOLD_CYCLES, ACK_TIMEOUT));
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ACK_LOAD  = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  sender_state_t             state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]     pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      flag_q, flag_d;
  logic                      timeout_q, timeout_d;
  logic                      req_q, req_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                      ack_sync;
  logic                      in_ready;
  logic                      accept;
  logic                      send;
  logic [DATA_WIDTH-1:0]     send_word;

  bit_synchronizer u_ack_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .SYNC_IN  (ACK_TOGGLE_IN),
    .SYNC_OUT (ack_sync)
  );

  // Ready: always in IDLE; elsewhere only while the pending slot can take a word.
  always_comb begin
    in_ready = 1'b0;
    if (!RESET) begin
      if (state_q == ST_IDLE) begin
        in_ready = 1'b1;
      end else begin
        in_ready = !pend_valid_q || OVERWRITE;
      end
    end
  end

  assign accept = IN_VALID && in_ready;

  // Next-state logic: sequencing, pending slot, drop counter and send.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    data_d       = data_q;
    flag_d       = 1'b0;
    timeout_d    = 1'b0;
    req_d        = req_q;
    drop_d       = drop_q;
    send         = 1'b0;
    send_word    = pend_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // Oldest word goes first; a simultaneous input refills the slot.
          send         = 1'b1;
          send_word    = pend_data_q;
          pend_valid_d = accept;
          if (accept) begin
            pend_data_d = IN_DATA;
          end
        end else if (accept) begin
          send      = 1'b1;
          send_word = IN_DATA;
        end
      end

      ST_HOLD: begin
        if (timer_q == '0) begin
          if (USE_ACK) begin
            state_d = ST_WAIT_ACK;
            timer_d = ACK_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          // Give up and adopt the destination's level so a late ack is a no-op.
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          req_d     = ack_sync;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Input arriving while busy lands in the single pending slot.
    if ((state_q != ST_IDLE) && accept) begin
      if (pend_valid_q && (drop_q != DROP_MAX)) begin
        drop_d = drop_q + 1'b1;
      end
      pend_valid_d = 1'b1;
      pend_data_d  = IN_DATA;
    end

    if (send) begin
      data_d  = send_word;
      flag_d  = 1'b1;
      timer_d = HOLD_LOAD;
      state_d = ST_HOLD;
      // With ack enabled, toggle relative to the destination's current level so
      // an ack that straggled in while idle cannot satisfy the new request.
      req_d   = USE_ACK ? ~ack_sync : ~req_q;
    end
  end

  // State register with synchronous reset discarding everything in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      data_q       <= '0;
      flag_q       <= 1'b0;
      timeout_q    <= 1'b0;
      req_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
      timeout_q    <= timeout_d;
      req_q        <= req_d;
      drop_q       <= drop_d;
    end
  end

  assign IN_READY        = in_ready;
  assign CHANGE_FLAG_OUT = flag_q;
  assign DATA_OUT        = data_q;
  assign BUSY            = (state_q != ST_IDLE) || pend_valid_q;
  assign TIMEOUT         = timeout_q;
  assign DROP_COUNT      = drop_q;

endmodule

// File: tb/tb_clock_domain_sender.sv
// Bench for clock_domain_sender: three instances (overwrite, backpressure, ack)
// with a per-instance expected-word scoreboard popped on every flag.
module tb_clock_domain_sender;

  logic clk;
  logic rst;

  logic        in_valid [3];
  logic        in_ready [3];
  logic [11:0] in_data  [3];
  logic        flag     [3];
  logic [11:0] dout     [3];
  logic        busy     [3];
  logic        tmo      [3];
  logic [15:0] drop     [3];
  logic        ack_tie;
  logic        ack2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];
  logic [11:0] exp_q2 [$];

  int unsigned cyc = 0;
  int unsigned last_flag [3];
  int unsigned gap       [3];
  int unsigned flag_cnt  [3];
  int unsigned tmo_cnt   [3];
  int unsigned tmo_cyc   [3];
  logic [11:0] prev_dout [3];
  logic        rst_prev = 1'b1;
  bit          mon_have;
  logic [11:0] mon_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clock_domain_sender #(.OVERWRITE(1'b1)) dut_ow (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .IN_DATA(in_data[0]), .CHANGE_FLAG_OUT(flag[0]), .DATA_OUT(dout[0]),
    .ACK_TOGGLE_IN(ack_tie), .BUSY(busy[0]), .TIMEOUT(tmo[0]), .DROP_COUNT(drop[0])
  );

  clock_domain_sender #(.OVERWRITE(1'b0)) dut_bp (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .IN_DATA(in_data[1]), .CHANGE_FLAG_OUT(flag[1]), .DATA_OUT(dout[1]),
    .ACK_TOGGLE_IN(ack_tie), .BUSY(busy[1]), .TIMEOUT(tmo[1]), .DROP_COUNT(drop[1])
  );

  clock_domain_sender #(.USE_ACK(1'b1), .ACK_TIMEOUT(16)) dut_ack (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .IN_DATA(in_data[2]), .CHANGE_FLAG_OUT(flag[2]), .DATA_OUT(dout[2]),
    .ACK_TOGGLE_IN(ack2), .BUSY(busy[2]), .TIMEOUT(tmo[2]), .DROP_COUNT(drop[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int k, input logic [11:0] w);
    case (k)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  task automatic pop_exp(input int k, output bit have, output logic [11:0] w);
    have = 1'b0;
    w    = '0;
    case (k)
      0: if (exp_q0.size() > 0) begin have = 1'b1; w = exp_q0.pop_front(); end
      1: if (exp_q1.size() > 0) begin have = 1'b1; w = exp_q1.pop_front(); end
      default: if (exp_q2.size() > 0) begin have = 1'b1; w = exp_q2.pop_front(); end
    endcase
  endtask

  task automatic sync1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) sync1();
  endtask

  // Present one word starting now; hold it until accepted (bounded).
  task automatic drive(input int k, input logic [11:0] w, output int stalls);
    stalls      = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    @(negedge clk);
    while (!in_ready[k] && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready[k]) check_eq("accept_bound", 32'(in_ready[k]), 1);
    sync1();
    in_valid[k] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every flag pops one expected word; data must not move
  // between flags; flag spacing is at least HOLD_CYCLES+1.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (flag[k] === 1'b1) begin
        pop_exp(k, mon_have, mon_w);
        check_eq("flag_expected", 32'(mon_have), 1);
        if (mon_have) check_eq("flag_data", 32'(dout[k]), 32'(mon_w));
        if (flag_cnt[k] > 0) begin
          gap[k] = cyc - last_flag[k];
          check_eq("flag_spacing", 32'(gap[k] >= 9), 1);
        end
        last_flag[k] = cyc;
        flag_cnt[k]++;
      end else if (!rst && !rst_prev && (dout[k] !== prev_dout[k])) begin
        check_eq("dout_stable", 32'(dout[k]), 32'(prev_dout[k]));
      end
      if (tmo[k] === 1'b1) begin
        tmo_cnt[k]++;
        tmo_cyc[k] = cyc;
      end
      prev_dout[k] = dout[k];
    end
    rst_prev = rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    int st3;
    int busy_n;
    int unsigned ack_cyc;
    int unsigned cnt0;

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = '0;
      last_flag[k] = 0; gap[k] = 0; flag_cnt[k] = 0; tmo_cnt[k] = 0; tmo_cyc[k] = 0;
    end
    ack_tie = 1'b0;
    ack2    = 1'b0;
    rst     = 1'b1;

    // Reset held 3 cycles with a valid input waiting on instance 0.
    in_valid[0] = 1'b1;
    in_data[0]  = 12'h111;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_flag", 32'(flag[0]), 0);
    end
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", 32'(in_ready[k]), 0);
      check_eq("rst_busy", 32'(busy[k]), 0);
      check_eq("rst_dout", 32'(dout[k]), 0);
      check_eq("rst_drop", 32'(drop[k]), 0);
      check_eq("rst_timeout", 32'(tmo[k]), 0);
    end
    sync1();
    rst = 1'b0;
    push_exp(0, 12'h111);
    @(negedge clk);
    check_eq("release_ready", 32'(in_ready[0]), 1);
    check_eq("release_no_flag_yet", 32'(flag[0]), 0);
    sync1();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("release_flag", 32'(flag[0]), 1);
    tick(12);
    check_eq("release_idle", 32'(busy[0]), 0);

    // Single send: flag next cycle, BUSY for exactly HOLD_CYCLES.
    push_exp(0, 12'hABC);
    drive(0, 12'hABC, st);
    check_eq("single_stall", 32'(st), 0);
    @(negedge clk);
    check_eq("single_flag", 32'(flag[0]), 1);
    check_eq("single_dout", 32'(dout[0]), 32'h0ABC);
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy[0]) busy_n++;
      @(negedge clk);
    end
    check_eq("single_busy_cycles", 32'(busy_n), 8);
    check_eq("single_dout_held", 32'(dout[0]), 32'h0ABC);

    // Burst with overwrite: middle word replaced, one drop.
    sync1();
    push_exp(0, 12'h001);
    push_exp(0, 12'h003);
    drive(0, 12'h001, st);
    drive(0, 12'h002, st3);
    st = st + st3;
    drive(0, 12'h003, st3);
    check_eq("ow_no_stall", 32'(st + st3), 0);
    tick(25);
    check_eq("ow_drop", 32'(drop[0]), 1);
    check_eq("ow_gap", gap[0], 9);

    // Burst with backpressure: third word stalls until IDLE, all three emitted.
    push_exp(1, 12'h001);
    push_exp(1, 12'h002);
    push_exp(1, 12'h003);
    drive(1, 12'h001, st);
    drive(1, 12'h002, st);
    drive(1, 12'h003, st3);
    check_eq("bp_stall_cycles", 32'(st3), 7);
    tick(30);
    check_eq("bp_drop", 32'(drop[1]), 0);
    check_eq("bp_flags", flag_cnt[1], 3);
    check_eq("bp_gap", gap[1], 9);

    // Ack mode: ack 20 cycles after flag; pending word waits for the synced ack.
    push_exp(2, 12'h0A5);
    push_exp(2, 12'h05A);
    drive(2, 12'h0A5, st);
    drive(2, 12'h05A, st);
    tick(19);
    ack2    = ~ack2;
    ack_cyc = cyc;
    tick(10);
    check_eq("ack_release_delay", last_flag[2] - ack_cyc, 4);
    check_eq("ack_no_timeout", tmo_cnt[2], 0);
    tick(20);
    check_eq("ack_timeout_cnt", tmo_cnt[2], 1);
    check_eq("ack_timeout_delay", tmo_cyc[2] - last_flag[2], 24);

    // Stale ack while idle must not release the next request early.
    ack2 = ~ack2;
    tick(5);
    push_exp(2, 12'h3C3);
    push_exp(2, 12'h3C4);
    drive(2, 12'h3C3, st);
    drive(2, 12'h3C4, st);
    tick(60);
    check_eq("stale_ack_gap", gap[2], 25);
    check_eq("stale_timeout_cnt", tmo_cnt[2], 3);

    // Reset during HOLD with a pending word: pending lost, no further flag.
    push_exp(0, 12'h0F0);
    drive(0, 12'h0F0, st);
    drive(0, 12'h0F1, st);
    sync1();
    rst = 1'b1;
    sync1();
    rst = 1'b0;
    cnt0 = flag_cnt[0];
    @(negedge clk);
    check_eq("mid_rst_no_flag", 32'(flag[0]), 0);
    check_eq("mid_rst_busy", 32'(busy[0]), 0);
    check_eq("mid_rst_drop", 32'(drop[0]), 0);
    check_eq("mid_rst_dout", 32'(dout[0]), 0);
    tick(30);
    check_eq("mid_rst_no_more_flags", flag_cnt[0], cnt0);

    check_eq("q0_drained", exp_q0.size(), 0);
    check_eq("q1_drained", exp_q1.size(), 0);
    check_eq("q2_drained", exp_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
